// File: rtl/wb_select_unit_pkg.sv
// Shared encodings for the write-back selector.
// Covers destination select, data source, load op and FSM state codes.
package cpu_defs_pkg;

    localparam logic [1:0] A3_RD   = 2'd0;
    localparam logic [1:0] A3_RT   = 2'd1;
    localparam logic [1:0] A3_LINK = 2'd2;
    localparam logic [1:0] A3_NONE = 2'd3;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_PC8 = 2'd2;
    localparam logic [1:0] WD_MDU = 2'd3;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MDU = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_select_unit_if.sv
// MEM-to-WB bundle: instruction fields and sources in, register-file write out.
// master = MEM side / consumer of wr_*, slave = write-back selector.
interface wb_select_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              reg_write;
    logic [1:0]        a3_sel;
    logic [1:0]        wd_sel;
    logic [2:0]        ld_op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] dm_out;
    logic [DATA_W-1:0] pc_plus8;
    logic              mdu_busy;
    logic [DATA_W-1:0] mdu_result;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              align_err;

    modport master (
        output flush, in_valid, reg_write, a3_sel, wd_sel, ld_op,
        output rd, rt, alu_out, dm_out, pc_plus8, mdu_busy, mdu_result,
        input  in_ready, wr_en, wr_addr, wr_data, align_err
    );

    modport slave (
        input  flush, in_valid, reg_write, a3_sel, wd_sel, ld_op,
        input  rd, rt, alu_out, dm_out, pc_plus8, mdu_busy, mdu_result,
        output in_ready, wr_en, wr_addr, wr_data, align_err
    );

endinterface

// File: rtl/wb_select_unit_load_ext.sv
// Sub-word load extraction and sign/zero extension.
// Ports: ld_op, offset (byte addr [1:0]), dm_out in; ext_data, misalign out.
module load_ext
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        ld_op,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] dm_out,
    output logic [DATA_W-1:0] ext_data,
    output logic              misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword select ignores offset[0]; misalignment is flagged instead.
    assign byte_sel = dm_out[{offset, 3'b000} +: 8];
    assign half_sel = dm_out[{offset[1], 4'b0000} +: 16];

    always_comb begin
        ext_data = dm_out;
        misalign = 1'b0;
        unique case (ld_op)
            LD_LB: ext_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_LBU: ext_data = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_LH: begin
                ext_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
                misalign = offset[0];
            end
            LD_LHU: begin
                ext_data = {{(DATA_W-16){1'b0}}, half_sel};
                misalign = offset[0];
            end
            default: misalign = (offset != 2'b00);
        endcase
    end

endmodule

// File: rtl/wb_select_unit.sv
// Write-back selector: destination/data mux, MDU stall FSM, output register.
// Ports: clk, reset (async, active-low), bus (slave side of wb_select_unit_if).
module wb_select_unit
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic            clk,
    input  logic            reset,
    wb_select_unit_if.slave bus
);

    wb_state_t         state, state_n;
    logic              accept;
    logic              stall;
    logic              capture;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] ext_data;
    logic              misalign;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_we;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              align_q;

    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .ld_op    (bus.ld_op),
        .offset   (bus.alu_out[1:0]),
        .dm_out   (bus.dm_out),
        .ext_data (ext_data),
        .misalign (misalign)
    );

    always_comb begin
        addr = '0;
        unique case (bus.a3_sel)
            A3_RD:   addr = bus.rd;
            A3_RT:   addr = bus.rt;
            A3_LINK: addr = ADDR_W'(LINK_REG);
            default: addr = '0;
        endcase
    end

    // Writes to $0 and reserved selects never reach the register file.
    assign we = bus.reg_write && (bus.a3_sel != A3_NONE) && (addr != '0);

    always_comb begin
        data = bus.alu_out;
        unique case (bus.wd_sel)
            WD_ALU:  data = bus.alu_out;
            WD_DM:   data = ext_data;
            WD_PC8:  data = bus.pc_plus8;
            default: data = bus.mdu_result;
        endcase
    end

    assign bus.in_ready = (state == IDLE);
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;
    assign stall  = (bus.wd_sel == WD_MDU) && bus.mdu_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Flush has priority over the MDU finishing in the same cycle.
    always_comb begin
        state_n = state;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && stall) state_n = WAIT_MDU;
            end
            WAIT_MDU: begin
                if (bus.flush) begin
                    state_n = IDLE;
                end else if (!bus.mdu_busy) begin
                    state_n = IDLE;
                    capture = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_addr <= '0;
            hold_we   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            align_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            align_q <= 1'b0;
            if (accept) begin
                wr_addr_q <= addr;
                wr_data_q <= data;
                if (stall) begin
                    hold_addr <= addr;
                    hold_we   <= we;
                end else begin
                    wr_en_q <= we;
                    align_q <= misalign && (bus.wd_sel == WD_DM);
                end
            end else if (capture) begin
                wr_addr_q <= hold_addr;
                wr_data_q <= bus.mdu_result;
                wr_en_q   <= hold_we;
            end
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.align_err = align_q;

endmodule

// File: tb/tb_wb_select_unit.sv
// Directed self-checking bench for wb_select_unit.
// Drives the MEM-side bundle and checks the registered write-back outputs.
module tb_wb_select_unit;
    import cpu_defs_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    wb_select_unit_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_select_unit #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [4:0] r, input logic [31:0] v);
        bus.in_valid  = 1'b1;
        bus.reg_write = 1'b1;
        bus.a3_sel    = A3_RD;
        bus.wd_sel    = WD_ALU;
        bus.rd        = r;
        bus.alu_out   = v;
    endtask

    logic [2:0]  ld_ops [5];
    logic [1:0]  ld_offs[5];
    logic [31:0] ld_exp [5];
    logic        ld_al  [5];

    initial begin
        checks   = 0;
        failures = 0;
        ld_ops  = '{LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LH};
        ld_offs = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
        ld_exp  = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                    32'h0000_7F01, 32'h0000_7F01};
        ld_al   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        bus.flush = 0; bus.in_valid = 0; bus.reg_write = 0;
        bus.a3_sel = 0; bus.wd_sel = 0; bus.ld_op = 0;
        bus.rd = 0; bus.rt = 0; bus.alu_out = 0; bus.dm_out = 0;
        bus.pc_plus8 = 0; bus.mdu_busy = 0; bus.mdu_result = 0;
        rst_n = 1'b0;
        #12;
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_align", 32'(bus.align_err), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        alu_op(5'd5, 32'h1234);
        step();
        check("alu_wr_en", 32'(bus.wr_en), 32'd1);
        check("alu_wr_addr", 32'(bus.wr_addr), 32'd5);
        check("alu_wr_data", bus.wr_data, 32'h1234);

        bus.wd_sel = WD_DM;
        bus.rd     = 5'd7;
        bus.dm_out = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            bus.ld_op   = ld_ops[i];
            bus.alu_out = {30'h0000_0400, ld_offs[i]};
            step();
            check($sformatf("ld%0d_data", i), bus.wr_data, ld_exp[i]);
            check($sformatf("ld%0d_align", i), 32'(bus.align_err),
                  32'(ld_al[i]));
            check($sformatf("ld%0d_wr_en", i), 32'(bus.wr_en), 32'd1);
        end
        bus.ld_op = LD_LW;

        bus.a3_sel   = A3_LINK;
        bus.wd_sel   = WD_PC8;
        bus.pc_plus8 = 32'h3008;
        step();
        check("link_wr_en", 32'(bus.wr_en), 32'd1);
        check("link_addr", 32'(bus.wr_addr), 32'd31);
        check("link_data", bus.wr_data, 32'h3008);
        check("link_align", 32'(bus.align_err), 32'd0);

        alu_op(5'd0, 32'h77);
        step();
        check("zero_wr_en", 32'(bus.wr_en), 32'd0);
        alu_op(5'd4, 32'h77);
        bus.a3_sel = A3_NONE;
        step();
        check("none_wr_en", 32'(bus.wr_en), 32'd0);

        alu_op(5'd6, 32'h99);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("idle_flush_wr_en", 32'(bus.wr_en), 32'd0);

        alu_op(5'd9, 32'h0);
        bus.wd_sel     = WD_MDU;
        bus.mdu_busy   = 1'b1;
        bus.mdu_result = 32'hCAFE;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mdu_ready%0d", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("mdu_noen%0d", i), 32'(bus.wr_en), 32'd0);
            if (i < 2) step();
        end
        bus.mdu_busy = 1'b0;
        step();
        check("mdu_wr_en", 32'(bus.wr_en), 32'd1);
        check("mdu_addr", 32'(bus.wr_addr), 32'd9);
        check("mdu_data", bus.wr_data, 32'hCAFE);
        check("mdu_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("mdu_one_shot", 32'(bus.wr_en), 32'd0);

        alu_op(5'd8, 32'h0);
        bus.wd_sel   = WD_MDU;
        bus.mdu_busy = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        bus.mdu_busy = 1'b0;
        step();
        bus.flush = 1'b0;
        check("wflush_wr_en", 32'(bus.wr_en), 32'd0);
        check("wflush_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("wflush_no_late", 32'(bus.wr_en), 32'd0);
        alu_op(5'd3, 32'h55);
        step();
        check("wflush_next_en", 32'(bus.wr_en), 32'd1);
        check("wflush_next_addr", 32'(bus.wr_addr), 32'd3);

        alu_op(5'd12, 32'h0);
        bus.wd_sel   = WD_MDU;
        bus.mdu_busy = 1'b1;
        step();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_wr_en", 32'(bus.wr_en), 32'd0);
        check("mrst_addr", 32'(bus.wr_addr), 32'd0);
        check("mrst_data", bus.wr_data, 32'd0);
        check("mrst_ready", 32'(bus.in_ready), 32'd1);
        bus.mdu_busy = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_op(5'(10 + i), 32'h100 + 32'(i));
            step();
            check($sformatf("b2b%0d_en", i), 32'(bus.wr_en), 32'd1);
            check($sformatf("b2b%0d_addr", i), 32'(bus.wr_addr),
                  32'(10 + i));
            check($sformatf("b2b%0d_data", i), bus.wr_data,
                  32'h100 + 32'(i));
        end
        bus.in_valid = 1'b0;
        step();
        check("b2b_idle_en", 32'(bus.wr_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
